core_arf_multi: RTL



---
 rtl/core_arf_pkg.sv | 24 ++
 rtl/core_arf_multi_if.sv | 32 +++
 rtl/core_arf_wsel.sv | 37 +++
 rtl/core_arf_multi.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/core_arf_pkg.sv
// rtl/core_arf_pkg.sv - shared constants, clear-FSM state type and write-port priority helper for the register file
package core_arf_pkg;

    localparam int XLEN_DEF   = 16;
    localparam int NREGS_DEF  = 16;
    // Upper bound on write ports handled by the priority helper.
    localparam int MAX_WPORTS = 32;

    typedef enum logic {
        IDLE,
        CLEAR
    } arf_clr_state_e;

    // Index of the highest set bit (highest-priority write port); 0 when none set.
    function automatic int top_hit(input logic [MAX_WPORTS-1:0] hits);
        int r;
        r = 0;
        for (int j = 0; j < MAX_WPORTS; j++) begin
            if (hits[j]) r = j;
        end
        return r;
    endfunction

endpackage

// File: rtl/core_arf_multi_if.sv
// rtl/core_arf_multi_if.sv - read/write/reserve/clear bundle between pipeline stages and the register file
// master: issue/writeback side (drives addresses, write data, reserve, clear request)
// slave : register file (drives read data, read ready, clear busy, pending bits)
interface core_arf_multi_if #(
    parameter int XLEN    = 16,
    parameter int NREGS   = 16,
    parameter int R_PORTS = 3,
    parameter int W_PORTS = 2,
    parameter int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
);
    logic [R_PORTS*AW-1:0]   rd_addr;
    logic [R_PORTS*XLEN-1:0] rd_data;
    logic [R_PORTS-1:0]      rd_ready;
    logic [W_PORTS-1:0]      wr_en;
    logic [W_PORTS*AW-1:0]   wr_addr;
    logic [W_PORTS*XLEN-1:0] wr_data;
    logic                    rsv_en;
    logic [AW-1:0]           rsv_addr;
    logic                    clr_req;
    logic                    clr_busy;
    logic [NREGS-1:0]        pend;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        input  rd_data, rd_ready, clr_busy, pend
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        output rd_data, rd_ready, clr_busy, pend
    );
endinterface

// File: rtl/core_arf_wsel.sv
// rtl/core_arf_wsel.sv - combinational highest-priority write-port match for one address
// addr    : address to look up
// wr_*    : all write ports (enable, address, data)
// hit     : some enabled port targets addr
// data    : data of the highest-index matching port
// idx     : index of that port
module core_arf_wsel
    import core_arf_pkg::*;
#(
    parameter int XLEN    = 16,
    parameter int AW      = 4,
    parameter int W_PORTS = 2,
    parameter int IW      = 1
) (
    input  logic [AW-1:0]           addr,
    input  logic [W_PORTS-1:0]      wr_en,
    input  logic [W_PORTS*AW-1:0]   wr_addr,
    input  logic [W_PORTS*XLEN-1:0] wr_data,
    output logic                    hit,
    output logic [XLEN-1:0]         data,
    output logic [IW-1:0]           idx
);
    logic [W_PORTS-1:0] hits;

    always_comb begin
        hits = '0;
        for (int j = 0; j < W_PORTS; j++) begin
            hits[j] = wr_en[j] && (wr_addr[j*AW +: AW] == addr);
        end
        hit  = |hits;
        idx  = IW'(top_hit(MAX_WPORTS'(hits)));
        data = '0;
        for (int j = 0; j < W_PORTS; j++) begin
            if (IW'(j) == idx) data = wr_data[j*XLEN +: XLEN];
        end
    end
endmodule

// File: rtl/core_arf_multi.sv
// rtl/core_arf_multi.sv - multi-port register file with R0-zero, write bypass, pending scoreboard and clear engine
// clk_i  : clock
// rst_ni : asynchronous active-low reset
// bus    : slave side of core_arf_multi_if (reads, writes, reserve, clear, pending bits)
module core_arf_multi
    import core_arf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int R_PORTS = 3,
    parameter int W_PORTS = 2,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    core_arf_multi_if.slave bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int IW = (W_PORTS > 1) ? $clog2(W_PORTS) : 1;
    // Counter and range compares are one bit wider so NREGS = 2^AW never wraps.
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW:0] LAST    = (AW+1)'(NREGS - 1);

    arf_clr_state_e   state;
    logic [AW:0]      cnt;
    logic             busy;
    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pend;

    logic [XLEN-1:0]  rd_data_a [R_PORTS];
    logic             rd_ready_a [R_PORTS];
    logic [IW-1:0]    rd_idx_unused [R_PORTS];

    logic [NREGS-1:0] cm_hit;
    logic [XLEN-1:0]  cm_data [NREGS];
    logic [IW-1:0]    cm_idx_unused [NREGS];
    logic [NREGS-1:0] wr_commit;
    logic             rsv_ok;

    // Read ports: zero/out-of-range first, then bypass of a committing write, then storage.
    for (genvar i = 0; i < R_PORTS; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic            in_range;
        logic            is_zero;
        logic            byp;

        assign a        = bus.rd_addr[i*AW +: AW];
        assign in_range = {1'b0, a} < NREGS_W;
        assign is_zero  = ZERO_R0 && (a == '0);

        core_arf_wsel #(
            .XLEN(XLEN), .AW(AW), .W_PORTS(W_PORTS), .IW(IW)
        ) u_wsel (
            .addr(a), .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
            .hit(byp_hit), .data(byp_data), .idx(rd_idx_unused[i])
        );

        // Writes dropped by the clear engine are not forwarded either.
        assign byp = BYPASS && byp_hit && (state == IDLE);

        assign rd_data_a[i]  = (!in_range || is_zero) ? '0 : (byp ? byp_data : mem[a]);
        assign rd_ready_a[i] = busy ? 1'b0
                             : ((!in_range || is_zero) ? 1'b1 : (!pend[a] || byp));
    end

    always_comb begin
        bus.rd_data  = '0;
        bus.rd_ready = '0;
        for (int i = 0; i < R_PORTS; i++) begin
            bus.rd_data[i*XLEN +: XLEN] = rd_data_a[i];
            bus.rd_ready[i]             = rd_ready_a[i];
        end
    end

    // Per-register commit select: the highest-index write port targeting r wins.
    for (genvar r = 0; r < NREGS; r++) begin : g_cm
        core_arf_wsel #(
            .XLEN(XLEN), .AW(AW), .W_PORTS(W_PORTS), .IW(IW)
        ) u_wsel (
            .addr(AW'(r)), .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
            .hit(cm_hit[r]), .data(cm_data[r]), .idx(cm_idx_unused[r])
        );

        assign wr_commit[r] = cm_hit[r] && (state == IDLE) && !(ZERO_R0 && (r == 0));
    end

    assign rsv_ok = bus.rsv_en && (state == IDLE)
                 && ({1'b0, bus.rsv_addr} < NREGS_W)
                 && !(ZERO_R0 && (bus.rsv_addr == '0));

    // Storage and scoreboard. A reserve is assigned after the write release so it wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
            pend <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (state == CLEAR) begin
                    if (cnt == (AW+1)'(r)) begin
                        mem[r]  <= '0;
                        pend[r] <= 1'b0;
                    end
                end else begin
                    if (wr_commit[r]) begin
                        mem[r]  <= cm_data[r];
                        pend[r] <= 1'b0;
                    end
                    if (rsv_ok && (bus.rsv_addr == AW'(r))) pend[r] <= 1'b1;
                end
            end
        end
    end

    // Clear engine: one register per cycle, requests while clearing are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clr_busy = busy;
    assign bus.pend     = pend;
endmodule
